// File: rtl/ysyx_24090013_idu.sv
// ysyx_24090013_idu: handshaked decode stage with RAW scoreboard, flush and RUN/HALT control
module ysyx_24090013_idu #(
  parameter int XLEN = 32,
  parameter int SB_W = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wen,
  output logic [3:0]      out_aluc,
  output logic [7:0]      out_alucex,
  output logic            out_ebreak,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_addr,
  input  logic            flush,
  output logic            halted
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd;
  logic is_r, is_i, is_j, is_jalr, is_lui, is_auipc, is_sys, is_load, is_store, is_br;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm, src1, src2;
  logic [3:0] aluc;
  logic [7:0] alucex;
  logic use1, use2, rd_wen, ebreak, illegal, hazard, accept;
  logic [SB_W-1:0] cnt [32];
  logic [SB_W-1:0] cnt_nx [32];
  logic [SB_W-1:0] c;
  assign op       = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign rd       = in_inst[11:7];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign is_r     = op == 7'b0110011;
  assign is_i     = op == 7'b0010011;
  assign is_j     = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_sys   = op == 7'b1110011;
  assign is_load  = op == 7'b0000011;
  assign is_store = op == 7'b0100011;
  assign is_br    = op == 7'b1100011;
  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  always_comb begin
    aluc = is_r ? 4'd1 : is_i ? 4'd2 : is_j ? 4'd3 : is_jalr ? 4'd4 : is_lui ? 4'd5 :
           is_auipc ? 4'd6 : is_sys ? 4'd7 : is_load ? 4'd8 : is_store ? 4'd9 : is_br ? 4'd10 : 4'd0;
    use1 = is_r | is_i | is_jalr | is_load | is_store | is_br;
    use2 = is_r | is_store | is_br;
    rd_wen = (is_r | is_i | is_j | is_jalr | is_lui | is_auipc | is_load) & (rd != 5'd0);
    ebreak = in_inst == 32'h0010_0073;
    illegal = (aluc == 4'd0) | (is_sys & !ebreak);
    imm = (is_i | is_jalr | is_load) ? imm_i : is_store ? imm_s : is_br ? imm_b :
          (is_lui | is_auipc) ? imm_u : is_j ? imm_j : '0;
    src1 = use1 ? rs1_data : is_j ? imm_j : (is_lui | is_auipc) ? imm_u : '0;
    src2 = (is_r | is_br) ? rs2_data : (is_i | is_jalr | is_load) ? imm_i : is_store ? imm_s :
           (is_j | is_auipc) ? in_pc : '0;
    alucex = (is_r | is_br) ? {3'b0, in_inst[30], f3} :
             is_i ? {3'b0, (f3 == 3'b101) & in_inst[30], f3} :
             (is_load | is_store) ? {5'b0, f3} : 8'd0;
  end
  assign hazard = (use1 & (cnt[rs1_addr] != '0)) | (use2 & (cnt[rs2_addr] != '0)) |
                  (rd_wen & (&cnt[rd]));
  assign in_ready = (state == RUN) & !flush & !hazard & (!out_valid | out_ready);
  assign accept = in_valid & in_ready;
  assign halted = state == HALT;
  // increment first so a same-cycle retire of a 0 counter cancels it instead of being dropped
  always_comb begin
    c = '0;
    for (int k = 0; k < 32; k++) begin
      c = cnt[k] + SB_W'(accept && rd_wen && rd == 5'(k));
      c = c - SB_W'(wb_valid && wb_rd_addr == 5'(k) && c != '0);
      c = c - SB_W'(flush && out_valid && out_rd_wen && out_rd_addr == 5'(k) && c != '0);
      cnt_nx[k] = (k == 0) ? '0 : c;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_src1       <= '0;
      out_src2       <= '0;
      out_imm        <= '0;
      out_store_data <= '0;
      out_rd_addr    <= '0;
      out_rd_wen     <= 1'b0;
      out_aluc       <= '0;
      out_alucex     <= '0;
      out_ebreak     <= 1'b0;
      out_illegal    <= 1'b0;
      cnt            <= '{default: '0};
    end else begin
      cnt       <= cnt_nx;
      out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (accept && (ebreak || illegal)) state <= HALT;
      if (accept) begin
        out_pc         <= in_pc;
        out_src1       <= src1;
        out_src2       <= src2;
        out_imm        <= imm;
        out_store_data <= is_store ? rs2_data : '0;
        out_rd_addr    <= rd;
        out_rd_wen     <= rd_wen;
        out_aluc       <= aluc;
        out_alucex     <= alucex;
        out_ebreak     <= ebreak;
        out_illegal    <= illegal;
      end
    end
  end
endmodule
